// File: rtl/parser_pkg.sv
// Shared parser types: lookup FSM states, channel id and default key/action widths
// used by the extractors, the key arbiter and the searcher.
package parser_pkg;

    localparam int KEY_W_DEF = 45;
    localparam int ACT_W_DEF = 125;
    localparam int CH_W_DEF  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef logic [CH_W_DEF-1:0] ch_id_t;

endpackage

// File: rtl/key_arbiter_if.sv
// Extractor-side request bus and searcher-side key/action bus of the key arbiter.
// Handshake: a request moves when req_valid[i] & req_ready[i] at a rising edge; all *_valid outputs are one-cycle pulses.
interface key_arbiter_if #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3,
    parameter int KEY_W  = parser_pkg::KEY_W_DEF,
    parameter int ACT_W  = parser_pkg::ACT_W_DEF
);
    logic [NUM_CH-1:0]       req_valid;
    logic [NUM_CH*KEY_W-1:0] req_key;
    logic [NUM_CH-1:0]       req_ready;
    logic                    key_valid;
    logic [KEY_W-1:0]        key;
    logic [CH_W-1:0]         key_ch;
    logic                    act_valid;
    logic [ACT_W-1:0]        act;
    logic [NUM_CH-1:0]       act_out_valid;
    logic [ACT_W-1:0]        act_out;
    logic                    timeout_valid;
    logic [CH_W-1:0]         timeout_ch;
    logic                    busy;

    modport master (
        output req_valid, req_key, act_valid, act,
        input  req_ready, key_valid, key, key_ch, act_out_valid, act_out,
               timeout_valid, timeout_ch, busy
    );

    modport slave (
        input  req_valid, req_key, act_valid, act,
        output req_ready, key_valid, key, key_ch, act_out_valid, act_out,
               timeout_valid, timeout_ch, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending after last_grant, wrapping
// modulo NUM_CH (works for non-power-of-two channel counts).
module rr_pick #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   last_grant,
    output logic              found,
    output logic [CH_W-1:0]   pick
);
    // Two ascending passes: channels above last_grant first, then the wrapped low part.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && pending[j] && (j > int'(last_grant))) begin
                found = 1'b1;
                pick  = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && pending[j] && (j <= int'(last_grant))) begin
                found = 1'b1;
                pick  = CH_W'(j);
            end
        end
    end
endmodule

// File: rtl/key_arbiter.sv
// N-channel lookup arbiter: one buffered key per channel, round-robin issue to the searcher,
// one-hot action return. Optional watchdog enabled by defining KEY_ARB_TIMEOUT_EN.
module key_arbiter
    import parser_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int ACT_W   = ACT_W_DEF,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    key_arbiter_if.slave bus,
    output arb_state_e dbg_state
);
    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [KEY_W-1:0]  hold_q [NUM_CH];
    logic [KEY_W-1:0]  hold_d [NUM_CH];
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CH_W-1:0]   key_ch_q, key_ch_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic [ACT_W-1:0]  act_out_q, act_out_d;
    logic [NUM_CH-1:0] act_out_valid_q, act_out_valid_d;
    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;

`ifdef KEY_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_valid_q, timeout_valid_d;
    logic [CH_W-1:0]  timeout_ch_q, timeout_ch_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT < 2);
`endif

    rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .found      (pick_found),
        .pick       (pick_ch)
    );

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        hold_d          = hold_q;
        last_grant_d    = last_grant_q;
        key_ch_d        = key_ch_q;
        key_d           = key_q;
        key_valid_d     = 1'b0;
        act_out_d       = act_out_q;
        act_out_valid_d = '0;
`ifdef KEY_ARB_TIMEOUT_EN
        timer_d         = timer_q;
        timeout_valid_d = 1'b0;
        timeout_ch_d    = timeout_ch_q;
`endif
        // Empty slots accept independently of the lookup in flight.
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.req_valid[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                hold_d[i]    = bus.req_key[i*KEY_W +: KEY_W];
            end
        end
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    key_d        = hold_q[pick_ch];
                    key_ch_d     = pick_ch;
                    key_valid_d  = 1'b1;
                    last_grant_d = pick_ch;
                    state_d      = WAIT;
`ifdef KEY_ARB_TIMEOUT_EN
                    timer_d      = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.act_valid) begin
                    act_out_d           = bus.act;
                    act_out_valid_d     = NUM_CH'(1) << key_ch_q;
                    pending_d[key_ch_q] = 1'b0;
                    state_d             = IDLE;
                end
`ifdef KEY_ARB_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timeout_valid_d     = 1'b1;
                    timeout_ch_d        = key_ch_q;
                    pending_d[key_ch_q] = 1'b0;
                    state_d             = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            pending_q       <= '0;
            last_grant_q    <= CH_W'(NUM_CH - 1);
            key_ch_q        <= '0;
            key_q           <= '0;
            key_valid_q     <= 1'b0;
            act_out_q       <= '0;
            act_out_valid_q <= '0;
`ifdef KEY_ARB_TIMEOUT_EN
            timer_q         <= '0;
            timeout_valid_q <= 1'b0;
            timeout_ch_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            last_grant_q    <= last_grant_d;
            key_ch_q        <= key_ch_d;
            key_q           <= key_d;
            key_valid_q     <= key_valid_d;
            act_out_q       <= act_out_d;
            act_out_valid_q <= act_out_valid_d;
`ifdef KEY_ARB_TIMEOUT_EN
            timer_q         <= timer_d;
            timeout_valid_q <= timeout_valid_d;
            timeout_ch_q    <= timeout_ch_d;
`endif
        end
    end

    // Key slots are only read while their pending bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign bus.req_ready     = ~pending_q;
    assign bus.key_valid     = key_valid_q;
    assign bus.key           = key_q;
    assign bus.key_ch        = key_ch_q;
    assign bus.act_out_valid = act_out_valid_q;
    assign bus.act_out       = act_out_q;
    assign bus.busy          = (state_q == WAIT);
    assign dbg_state         = state_q;
`ifdef KEY_ARB_TIMEOUT_EN
    assign bus.timeout_valid = timeout_valid_q;
    assign bus.timeout_ch    = timeout_ch_q;
`else
    assign bus.timeout_valid = 1'b0;
    assign bus.timeout_ch    = '0;
`endif
endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter: an 8-channel instance for the main scenarios and a
// 5-channel instance for round-robin wrap-around. Watchdog cases need KEY_ARB_TIMEOUT_EN.
module tb_key_arbiter;
    import parser_pkg::*;

    localparam int KW = 45;
    localparam int AW = 125;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_arbiter_if #(.NUM_CH(8), .CH_W(3), .KEY_W(KW), .ACT_W(AW)) bus8 ();
    key_arbiter_if #(.NUM_CH(5), .CH_W(3), .KEY_W(KW), .ACT_W(AW)) bus5 ();
    arb_state_e st8, st5;

    key_arbiter #(.NUM_CH(8), .CH_W(3), .KEY_W(KW), .ACT_W(AW), .TIMEOUT(16)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8), .dbg_state(st8)
    );
    key_arbiter #(.NUM_CH(5), .CH_W(3), .KEY_W(KW), .ACT_W(AW), .TIMEOUT(16)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5), .dbg_state(st5)
    );

    int n_checks = 0;
    int n_bad = 0;
    logic [8*KW-1:0] rk8;
    logic [5*KW-1:0] rk5;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus8.req_valid = '0; bus8.req_key = '0; bus8.act_valid = 1'b0; bus8.act = '0;
        bus5.req_valid = '0; bus5.req_key = '0; bus5.act_valid = 1'b0; bus5.act = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        step(); step();
        n_checks++; if (bus8.key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_key_valid got=%0b exp=0", bus8.key_valid); end
        n_checks++; if (bus8.key !== '0) begin n_bad++; $display("FAIL rst_key got=%0h exp=0", bus8.key); end
        n_checks++; if (bus8.key_ch !== 3'd0) begin n_bad++; $display("FAIL rst_key_ch got=%0d exp=0", bus8.key_ch); end
        n_checks++; if (bus8.act_out_valid !== 8'h00) begin n_bad++; $display("FAIL rst_act_out_valid got=%0h exp=0", bus8.act_out_valid); end
        n_checks++; if (bus8.act_out !== '0) begin n_bad++; $display("FAIL rst_act_out got=%0h exp=0", bus8.act_out); end
        n_checks++; if (bus8.timeout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_valid got=%0b exp=0", bus8.timeout_valid); end
        n_checks++; if (bus8.timeout_ch !== 3'd0) begin n_bad++; $display("FAIL rst_timeout_ch got=%0d exp=0", bus8.timeout_ch); end
        n_checks++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0b exp=0", bus8.busy); end
        n_checks++; if (bus8.req_ready !== 8'hFF) begin n_bad++; $display("FAIL rst_req_ready got=%0h exp=ff", bus8.req_ready); end
        n_checks++; if (bus5.req_ready !== 5'h1F) begin n_bad++; $display("FAIL rst_req_ready5 got=%0h exp=1f", bus5.req_ready); end
        n_checks++; if (st8 !== IDLE) begin n_bad++; $display("FAIL rst_state got=%0d exp=IDLE", st8); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        rk8 = '0;
        rk8[2*KW +: KW] = 45'h1234;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b0000_0100;
        step();
        bus8.req_valid = '0;
        n_checks++; if (bus8.req_ready !== 8'hFB) begin n_bad++; $display("FAIL single_ready_low got=%0h exp=fb", bus8.req_ready); end
        n_checks++; if (bus8.key_valid !== 1'b0) begin n_bad++; $display("FAIL single_no_early_key got=%0b exp=0", bus8.key_valid); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b1) begin n_bad++; $display("FAIL single_key_valid got=%0b exp=1", bus8.key_valid); end
        n_checks++; if (bus8.key_ch !== 3'd2) begin n_bad++; $display("FAIL single_key_ch got=%0d exp=2", bus8.key_ch); end
        n_checks++; if (bus8.key !== 45'h1234) begin n_bad++; $display("FAIL single_key got=%0h exp=1234", bus8.key); end
        n_checks++; if (st8 !== WAIT || bus8.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%0b exp=1", bus8.busy); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b0) begin n_bad++; $display("FAIL single_key_pulse got=%0b exp=0", bus8.key_valid); end
        step(); step();
        bus8.act_valid = 1'b1;
        bus8.act = 125'hABC;
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'b0000_0100) begin n_bad++; $display("FAIL single_act_out_valid got=%0b exp=00000100", bus8.act_out_valid); end
        n_checks++; if (bus8.act_out !== 125'hABC) begin n_bad++; $display("FAIL single_act_out got=%0h exp=abc", bus8.act_out); end
        n_checks++; if (bus8.req_ready !== 8'hFF) begin n_bad++; $display("FAIL single_ready_back got=%0h exp=ff", bus8.req_ready); end
        n_checks++; if (bus8.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got=%0b exp=0", bus8.busy); end
        step();
        n_checks++; if (bus8.act_out_valid !== 8'h00) begin n_bad++; $display("FAIL single_act_pulse got=%0h exp=0", bus8.act_out_valid); end
        n_checks++; if (bus8.act_out !== 125'hABC) begin n_bad++; $display("FAIL single_act_hold got=%0h exp=abc", bus8.act_out); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_q[$];
        logic [KW-1:0] key_q[$];
        logic [2:0] ch;
        logic [KW-1:0] k;
        exp_q = '{3'd0, 3'd3, 3'd7, 3'd0};
        key_q = '{45'h100, 45'h300, 45'h700, 45'h101};
        do_reset();
        rk8 = '0;
        rk8[0*KW +: KW] = 45'h100;
        rk8[3*KW +: KW] = 45'h300;
        rk8[7*KW +: KW] = 45'h700;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b1000_1001;
        step();
        bus8.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus8.req_valid = '0;
            ch = exp_q.pop_front();
            k = key_q.pop_front();
            n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key_ch !== ch) begin n_bad++; $display("FAIL fair_grant%0d got=%0b/%0d exp=1/%0d", i, bus8.key_valid, bus8.key_ch, ch); end
            n_checks++; if (bus8.key !== k) begin n_bad++; $display("FAIL fair_key%0d got=%0h exp=%0h", i, bus8.key, k); end
            bus8.act_valid = 1'b1;
            bus8.act = 125'(16'hA0 + i);
            step();
            bus8.act_valid = 1'b0;
            n_checks++; if (bus8.act_out_valid !== (8'd1 << ch) || bus8.act_out !== 125'(16'hA0 + i)) begin n_bad++; $display("FAIL fair_act%0d got=%0b/%0h exp=%0b/%0h", i, bus8.act_out_valid, bus8.act_out, 8'd1 << ch, 16'hA0 + i); end
            if (i == 0) begin
                rk8 = '0;
                rk8[0*KW +: KW] = 45'h101;
                bus8.req_key = rk8;
                bus8.req_valid = 8'b0000_0001;
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_q[$];
        logic [KW-1:0] key_q[$];
        logic [2:0] ch;
        logic [KW-1:0] k;
        exp_q = '{3'd0, 3'd4, 3'd0, 3'd3};
        key_q = '{45'h10, 45'h14, 45'h20, 45'h23};
        do_reset();
        rk5 = '0;
        rk5[0*KW +: KW] = 45'h10;
        rk5[4*KW +: KW] = 45'h14;
        bus5.req_key = rk5;
        bus5.req_valid = 5'b1_0001;
        step();
        bus5.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            ch = exp_q.pop_front();
            k = key_q.pop_front();
            n_checks++; if (bus5.key_valid !== 1'b1 || bus5.key_ch !== ch || bus5.key !== k) begin n_bad++; $display("FAIL wrap_grant%0d got=%0b/%0d/%0h exp=1/%0d/%0h", i, bus5.key_valid, bus5.key_ch, bus5.key, ch, k); end
            bus5.act_valid = 1'b1;
            bus5.act = 125'(i + 1);
            if (i == 1) begin
                rk5 = '0;
                rk5[0*KW +: KW] = 45'h20;
                rk5[3*KW +: KW] = 45'h23;
                bus5.req_key = rk5;
                bus5.req_valid = 5'b0_1001;
            end
            step();
            bus5.act_valid = 1'b0;
            bus5.req_valid = '0;
            n_checks++; if (bus5.act_out_valid !== (5'd1 << ch)) begin n_bad++; $display("FAIL wrap_act%0d got=%0b exp=%0b", i, bus5.act_out_valid, 5'd1 << ch); end
        end
    endtask

    task automatic test_backpressure();
        rk8 = '0;
        rk8[1*KW +: KW] = 45'hAAA;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b0000_0010;
        step();
        rk8[1*KW +: KW] = 45'hBBB;
        bus8.req_key = rk8;
        n_checks++; if (bus8.req_ready !== 8'hFD) begin n_bad++; $display("FAIL bp_ready_low got=%0h exp=fd", bus8.req_ready); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key !== 45'hAAA) begin n_bad++; $display("FAIL bp_first_key got=%0b/%0h exp=1/aaa", bus8.key_valid, bus8.key); end
        step();
        n_checks++; if (bus8.req_ready !== 8'hFD) begin n_bad++; $display("FAIL bp_still_blocked got=%0h exp=fd", bus8.req_ready); end
        bus8.act_valid = 1'b1;
        bus8.act = 125'h111;
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'b0000_0010 || bus8.req_ready !== 8'hFF) begin n_bad++; $display("FAIL bp_release got=%0b/%0h exp=00000010/ff", bus8.act_out_valid, bus8.req_ready); end
        step();
        bus8.req_valid = '0;
        n_checks++; if (bus8.req_ready !== 8'hFD || bus8.key_valid !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got=%0h/%0b exp=fd/0", bus8.req_ready, bus8.key_valid); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key !== 45'hBBB || bus8.key_ch !== 3'd1) begin n_bad++; $display("FAIL bp_second_key got=%0b/%0h/%0d exp=1/bbb/1", bus8.key_valid, bus8.key, bus8.key_ch); end
        bus8.act_valid = 1'b1;
        bus8.act = 125'h222;
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'b0000_0010 || bus8.act_out !== 125'h222) begin n_bad++; $display("FAIL bp_second_act got=%0b/%0h exp=00000010/222", bus8.act_out_valid, bus8.act_out); end
    endtask

    task automatic test_reset_mid_wait();
        rk8 = '0;
        rk8[5*KW +: KW] = 45'h55;
        rk8[6*KW +: KW] = 45'h66;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b0110_0000;
        step();
        bus8.req_valid = '0;
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key_ch !== 3'd5) begin n_bad++; $display("FAIL rmw_grant got=%0b/%0d exp=1/5", bus8.key_valid, bus8.key_ch); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus8.act_valid = 1'b1;
        bus8.act = 125'h777;
        n_checks++; if (bus8.req_ready !== 8'hFF || bus8.busy !== 1'b0) begin n_bad++; $display("FAIL rmw_cleared got=%0h/%0b exp=ff/0", bus8.req_ready, bus8.busy); end
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'h00) begin n_bad++; $display("FAIL rmw_late_act got=%0h exp=0", bus8.act_out_valid); end
        n_checks++; if (bus8.key_valid !== 1'b0 || bus8.req_ready !== 8'hFF) begin n_bad++; $display("FAIL rmw_no_regrant got=%0b/%0h exp=0/ff", bus8.key_valid, bus8.req_ready); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b0 || bus8.busy !== 1'b0) begin n_bad++; $display("FAIL rmw_idle got=%0b/%0b exp=0/0", bus8.key_valid, bus8.busy); end
    endtask

`ifdef KEY_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        rk8 = '0;
        rk8[4*KW +: KW] = 45'h44;
        rk8[6*KW +: KW] = 45'h66;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b0101_0000;
        step();
        bus8.req_valid = '0;
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key_ch !== 3'd4) begin n_bad++; $display("FAIL wd_grant got=%0b/%0d exp=1/4", bus8.key_valid, bus8.key_ch); end
        for (int k = 1; k < 16; k++) begin
            step();
            n_checks++; if (bus8.timeout_valid !== 1'b0 || bus8.busy !== 1'b1) begin n_bad++; $display("FAIL wd_early%0d got=%0b/%0b exp=0/1", k, bus8.timeout_valid, bus8.busy); end
        end
        step();
        n_checks++; if (bus8.timeout_valid !== 1'b1 || bus8.timeout_ch !== 3'd4) begin n_bad++; $display("FAIL wd_expire got=%0b/%0d exp=1/4", bus8.timeout_valid, bus8.timeout_ch); end
        n_checks++; if (bus8.act_out_valid !== 8'h00 || bus8.req_ready !== 8'hBF) begin n_bad++; $display("FAIL wd_release got=%0h/%0h exp=0/bf", bus8.act_out_valid, bus8.req_ready); end
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key_ch !== 3'd6 || bus8.timeout_valid !== 1'b0) begin n_bad++; $display("FAIL wd_next got=%0b/%0d/%0b exp=1/6/0", bus8.key_valid, bus8.key_ch, bus8.timeout_valid); end
        for (int k = 1; k < 16; k++) step();
        bus8.act_valid = 1'b1;
        bus8.act = 125'h5A5;
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'b0100_0000 || bus8.timeout_valid !== 1'b0) begin n_bad++; $display("FAIL wd_act_wins got=%0b/%0b exp=01000000/0", bus8.act_out_valid, bus8.timeout_valid); end
    endtask
`else
    task automatic test_no_watchdog();
        rk8 = '0;
        rk8[5*KW +: KW] = 45'h5;
        bus8.req_key = rk8;
        bus8.req_valid = 8'b0010_0000;
        step();
        bus8.req_valid = '0;
        step();
        n_checks++; if (bus8.key_valid !== 1'b1 || bus8.key_ch !== 3'd5) begin n_bad++; $display("FAIL nowd_grant got=%0b/%0d exp=1/5", bus8.key_valid, bus8.key_ch); end
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++; if (bus8.timeout_valid !== 1'b0 || bus8.busy !== 1'b1) begin n_bad++; $display("FAIL nowd_hold%0d got=%0b/%0b exp=0/1", k, bus8.timeout_valid, bus8.busy); end
        end
        bus8.act_valid = 1'b1;
        bus8.act = 125'h5A5;
        step();
        bus8.act_valid = 1'b0;
        n_checks++; if (bus8.act_out_valid !== 8'b0010_0000 || bus8.act_out !== 125'h5A5) begin n_bad++; $display("FAIL nowd_act got=%0b/%0h exp=00100000/5a5", bus8.act_out_valid, bus8.act_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_reset_mid_wait();
`ifdef KEY_ARB_TIMEOUT_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
